// File: rtl/tdc_acc_if.sv
// Result handshake between tdc_acc and the digital back end.
// The producer drives valid/sum/last/ovf; the consumer drives ready.
interface tdc_acc_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ACC_W = 16
);
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_last;
  logic             out_ovf;

  modport master (
    output out_valid,
    output out_sum,
    output out_last,
    output out_ovf,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_sum,
    input  out_last,
    input  out_ovf,
    output out_ready
  );
endinterface

// File: rtl/tdc_acc.sv
// Start/stop TDC that sums N_ACC clk-quantised delays into one saturating result.
// Define TDC_SYNC_EN to add a 2-flop synchroniser on start/stop ahead of rise detection.
module tdc_acc #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned T_MAX = 255,
  parameter int unsigned N_ACC = 4,
  parameter int unsigned ACC_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         start,
  input  logic         stop,
  tdc_acc_if.master    res
);

  localparam int unsigned SW = (N_ACC > 1) ? $clog2(N_ACC) : 1;
  localparam logic [CNT_W-1:0] TMax = CNT_W'(T_MAX);
  localparam logic [SW-1:0]    LastIdx = SW'(N_ACC - 1);

  typedef enum logic [2:0] {StIdle, StArmed, StCount, StAcc, StDone} state_e;

  logic start_in, stop_in;

`ifdef TDC_SYNC_EN
  logic start_m_q, stop_m_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_m_q <= 1'b0;
      stop_m_q  <= 1'b0;
    end else begin
      start_m_q <= start;
      stop_m_q  <= stop;
    end
  end

  assign start_in = start_m_q;
  assign stop_in  = stop_m_q;
`else
  assign start_in = start;
  assign stop_in  = stop;
`endif

  logic start_s_q, start_s_q_d, stop_s_q, stop_s_q_d;
  logic start_rise, stop_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_s_q   <= 1'b0;
      start_s_q_d <= 1'b0;
      stop_s_q    <= 1'b0;
      stop_s_q_d  <= 1'b0;
    end else begin
      start_s_q   <= start_in;
      start_s_q_d <= start_s_q;
      stop_s_q    <= stop_in;
      stop_s_q_d  <= stop_s_q;
    end
  end

  assign start_rise = start_s_q & ~start_s_q_d;
  assign stop_rise  = stop_s_q & ~stop_s_q_d;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, count_q, last_q;
  logic [SW-1:0]    samp_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q, valid_q;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W-1:0] cnt_inc;

  // One spare bit catches the carry that signals saturation.
  assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(count_q);
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      count_q <= '0;
      last_q  <= '0;
      samp_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          valid_q <= 1'b0;
          if (en) state_q <= StArmed;
        end
        StArmed: begin
          if (!en) begin
            state_q <= StIdle;
          end else if (start_rise) begin
            cnt_q <= '0;
            if (stop_rise) begin
              count_q <= '0;
              state_q <= StAcc;
            end else begin
              state_q <= StCount;
            end
          end
        end
        StCount: begin
          // cnt_q lags the elapsed cycle count by one, so compare against cnt_q + 1.
          if (stop_rise) begin
            count_q <= cnt_inc;
            state_q <= StAcc;
          end else if (cnt_inc == TMax) begin
            count_q <= TMax;
            ovf_q   <= 1'b1;
            state_q <= StAcc;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StAcc: begin
          if (sum_ext[ACC_W]) begin
            acc_q <= '1;
            ovf_q <= 1'b1;
          end else begin
            acc_q <= sum_ext[ACC_W-1:0];
          end
          last_q <= count_q;
          samp_q <= samp_q + 1'b1;
          if (samp_q == LastIdx) begin
            valid_q <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StArmed;
          end
        end
        StDone: begin
          if (res.out_ready) begin
            acc_q   <= '0;
            samp_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            state_q <= en ? StArmed : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign res.out_valid = valid_q;
  assign res.out_sum   = acc_q;
  assign res.out_last  = last_q;
  assign res.out_ovf   = ovf_q;

endmodule

// File: tb/tb_tdc_acc.sv
// Directed bench for tdc_acc: default instance plus an ACC_W=8/T_MAX=100 instance for saturation.
module tb_tdc_acc;

  logic clk, rst, en, en2, start, stop;
  int   n_checks, n_pass, hs_cnt;

  tdc_acc_if #(.CNT_W(8), .ACC_W(16)) io  ();
  tdc_acc_if #(.CNT_W(8), .ACC_W(8))  io2 ();

  tdc_acc #(.CNT_W(8), .T_MAX(255), .N_ACC(4), .ACC_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .stop  (stop),
    .res   (io.master)
  );

  tdc_acc #(.CNT_W(8), .T_MAX(100), .N_ACC(4), .ACC_W(8)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .en    (en2),
    .start (start),
    .stop  (stop),
    .res   (io2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (io.out_valid && io.out_ready) hs_cnt++;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Stop rises k clk cycles after start; no_stop holds start alone past the timeout.
  task automatic run_sample(input int k, input bit no_stop);
    repeat (4) @(negedge clk);
    start = 1'b1;
    if (!no_stop && k == 0) stop = 1'b1;
    if (no_stop) begin
      repeat (260) @(negedge clk);
    end else if (k > 0) begin
      repeat (k) @(negedge clk);
      stop = 1'b1;
    end
    repeat (3) @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int which);
    int i;
    i = 0;
    while (i < 40 && ((which == 2) ? io2.out_valid : io.out_valid) !== 1'b1) begin
      @(negedge clk);
      i++;
    end
    check_eq(tag, int'((which == 2) ? io2.out_valid : io.out_valid), 1);
  endtask

  task automatic handshake(input int which);
    @(negedge clk);
    if (which == 2) io2.out_ready = 1'b1;
    else            io.out_ready  = 1'b1;
    @(negedge clk);
    io.out_ready  = 1'b0;
    io2.out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    hs_cnt   = 0;
    rst = 1'b1; en = 1'b1; en2 = 1'b0; start = 1'b0; stop = 1'b0;
    io.out_ready  = 1'b0;
    io2.out_ready = 1'b0;

    // Reset with en held high
    repeat (2) @(negedge clk);
    check_eq("rst_valid", int'(io.out_valid), 0);
    check_eq("rst_sum",   int'(io.out_sum),   0);
    check_eq("rst_last",  int'(io.out_last),  0);
    check_eq("rst_ovf",   int'(io.out_ovf),   0);
    check_eq("rst_valid2", int'(io2.out_valid), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("idle_no_valid", int'(io.out_valid), 0);

    // Basic sum 3+5+0+7
    run_sample(3, 1'b0); check_eq("basic_last0", int'(io.out_last), 3);
    run_sample(5, 1'b0); check_eq("basic_last1", int'(io.out_last), 5);
    run_sample(0, 1'b0); check_eq("basic_last2", int'(io.out_last), 0);
    run_sample(7, 1'b0); check_eq("basic_last3", int'(io.out_last), 7);
    wait_valid("basic_valid", 1);
    check_eq("basic_sum", int'(io.out_sum), 15);
    check_eq("basic_ovf", int'(io.out_ovf), 0);
    handshake(1);
    check_eq("basic_valid_drop", int'(io.out_valid), 0);
    check_eq("basic_sum_clr",    int'(io.out_sum),   0);
    check_eq("basic_hs_once",    hs_cnt,             1);

    // Timeout clipped to 255
    run_sample(2, 1'b0);
    run_sample(0, 1'b1); check_eq("to_last", int'(io.out_last), 255);
    run_sample(2, 1'b0);
    run_sample(2, 1'b0);
    wait_valid("to_valid", 1);
    check_eq("to_sum", int'(io.out_sum), 261);
    check_eq("to_ovf", int'(io.out_ovf), 1);

    // Backpressure: edges while DONE must be ignored
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = ~start;
      stop  = (i % 4) < 2;
    end
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("bp_valid", int'(io.out_valid), 1);
    check_eq("bp_sum",   int'(io.out_sum),   261);
    check_eq("bp_ovf",   int'(io.out_ovf),   1);
    check_eq("bp_last",  int'(io.out_last),  2);
    handshake(1);
    check_eq("bp_valid_drop", int'(io.out_valid), 0);
    check_eq("bp_sum_clr",    int'(io.out_sum),   0);
    check_eq("bp_ovf_clr",    int'(io.out_ovf),   0);
    for (int i = 0; i < 4; i++) run_sample(1, 1'b0);
    wait_valid("bp_next_valid", 1);
    check_eq("bp_next_sum", int'(io.out_sum), 4);
    check_eq("bp_next_ovf", int'(io.out_ovf), 0);
    handshake(1);

    // Reset in the middle of sample 2's count
    run_sample(3, 1'b0);
    check_eq("mid_sum_pre", int'(io.out_sum), 3);
    repeat (4) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    check_eq("mid_rst_sum",   int'(io.out_sum),   0);
    check_eq("mid_rst_last",  int'(io.out_last),  0);
    check_eq("mid_rst_valid", int'(io.out_valid), 0);
    run_sample(2, 1'b0);
    run_sample(4, 1'b0);
    run_sample(6, 1'b0);
    run_sample(8, 1'b0);
    wait_valid("mid_valid", 1);
    check_eq("mid_sum",  int'(io.out_sum),  20);
    check_eq("mid_last", int'(io.out_last), 8);
    check_eq("mid_ovf",  int'(io.out_ovf),  0);
    handshake(1);

    // Saturation on the 8-bit instance: 100 x 4 -> 255
    en  = 1'b0;
    en2 = 1'b1;
    repeat (3) @(negedge clk);
    run_sample(100, 1'b0);
    run_sample(100, 1'b0);
    check_eq("sat_sum_mid", int'(io2.out_sum), 200);
    check_eq("sat_ovf_mid", int'(io2.out_ovf), 0);
    run_sample(100, 1'b0);
    run_sample(100, 1'b0);
    wait_valid("sat_valid", 2);
    check_eq("sat_sum",  int'(io2.out_sum),  255);
    check_eq("sat_ovf",  int'(io2.out_ovf),  1);
    check_eq("sat_last", int'(io2.out_last), 100);
    check_eq("sat_dut1_idle", int'(io.out_valid), 0);
    handshake(2);
    check_eq("sat_valid_drop", int'(io2.out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
